// File: rtl/audio_sched.sv
// Audio sample scheduler: paces BGM/SFX ROM reads off the audio FIFO, mixes with saturation, strobes the codec.
// Optional build macro AUDIO_SCHED_DUCK_EN halves background music while an effect plays.
module audio_sched #(
  parameter int unsigned DIV       = 8,
  parameter int unsigned BGM_LAST  = 54205,
  parameter int unsigned SFX0_BASE = 0,
  parameter int unsigned SFX0_LAST = 4095,
  parameter int unsigned SFX1_BASE = 4096,
  parameter int unsigned SFX1_LAST = 8191
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        audio_out_allowed,
  input  logic        bgm_en,
  input  logic [1:0]  sfx_req,
  output logic [15:0] bgm_addr,
  input  logic [9:0]  bgm_q,
  output logic [15:0] sfx_addr,
  input  logic [9:0]  sfx_q,
  output logic        sfx_busy,
  output logic        sfx_id,
  output logic [31:0] sample_out,
  output logic        write_audio_out
);

  localparam int unsigned DIV_W  = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam int unsigned ADDR_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MIX   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             tick;
  logic [DIV_W-1:0] div_cnt;

  logic signed [10:0] b_ext;
  logic signed [10:0] s_ext;
  logic signed [10:0] sum;
  logic [9:0]         sat;
  logic               start0;
  logic               start1;
  logic [ADDR_W-1:0]  sfx_last;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state; the divider tick only matters while idle
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      S_IDLE: begin
        if (audio_out_allowed && (div_cnt == DIV_W'(DIV))) begin
          tick      = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_MIX;
      S_MIX:   state_nxt = S_WRITE;
      S_WRITE: if (audio_out_allowed) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider is frozen whenever a sample is in flight
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt <= '0;
    end else if ((state == S_IDLE) && audio_out_allowed) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Mixer: 11-bit signed sum clamped to the 10-bit codec range
  always_comb begin
    b_ext = '0;
    if (bgm_en) begin
      b_ext = {bgm_q[9], bgm_q};
`ifdef AUDIO_SCHED_DUCK_EN
      if (sfx_busy) b_ext = b_ext >>> 1;
`endif
    end
    s_ext = sfx_busy ? {sfx_q[9], sfx_q} : 11'sd0;
    sum   = b_ext + s_ext;
    if (sum > 11'sd511)       sat = 10'h1FF;
    else if (sum < -11'sd512) sat = 10'h200;
    else                      sat = sum[9:0];
  end

  // Effect 1 may preempt effect 0; everything else is ignored while busy
  always_comb begin
    start1   = sfx_req[1] && !(sfx_busy && sfx_id);
    start0   = sfx_req[0] && !sfx_busy;
    sfx_last = sfx_id ? ADDR_W'(SFX1_LAST) : ADDR_W'(SFX0_LAST);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bgm_addr        <= '0;
      sfx_addr        <= '0;
      sfx_busy        <= 1'b0;
      sfx_id          <= 1'b0;
      sample_out      <= '0;
      write_audio_out <= 1'b0;
    end else begin
      write_audio_out <= (state == S_WRITE) && audio_out_allowed;

      if (state == S_MIX) begin
        sample_out <= {sat, 22'd0};
        if (bgm_en) begin
          bgm_addr <= (bgm_addr == ADDR_W'(BGM_LAST)) ? '0 : bgm_addr + ADDR_W'(1);
        end
      end

      // A fresh request overrides the MIX-step advance in the same cycle
      if (start1) begin
        sfx_busy <= 1'b1;
        sfx_id   <= 1'b1;
        sfx_addr <= ADDR_W'(SFX1_BASE);
      end else if (start0) begin
        sfx_busy <= 1'b1;
        sfx_id   <= 1'b0;
        sfx_addr <= ADDR_W'(SFX0_BASE);
      end else if ((state == S_MIX) && sfx_busy) begin
        if (sfx_addr == sfx_last) sfx_busy <= 1'b0;
        else                      sfx_addr <= sfx_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_sched.sv
// Scoreboard bench for audio_sched: stimulus pushes expected strobe contents, a negedge monitor pops and compares.
// ROM ranges are shrunk so effects and the BGM wrap complete in a few hundred cycles.
module tb_audio_sched;

  localparam int unsigned DIV      = 8;
  localparam int unsigned BGM_LAST = 20;
  localparam int unsigned S0B      = 0;
  localparam int unsigned S0L      = 9;
  localparam int unsigned S1B      = 4096;
  localparam int unsigned S1L      = 4111;

  logic        clk = 1'b0;
  logic        reset;
  logic        audio_out_allowed;
  logic        bgm_en;
  logic [1:0]  sfx_req;
  logic [15:0] bgm_addr;
  logic [9:0]  bgm_q;
  logic [15:0] sfx_addr;
  logic [9:0]  sfx_q;
  logic        sfx_busy;
  logic        sfx_id;
  logic [31:0] sample_out;
  logic        write_audio_out;

  always #5 clk = ~clk;

  audio_sched #(
    .DIV(DIV), .BGM_LAST(BGM_LAST),
    .SFX0_BASE(S0B), .SFX0_LAST(S0L), .SFX1_BASE(S1B), .SFX1_LAST(S1L)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .audio_out_allowed(audio_out_allowed),
    .bgm_en(bgm_en), .sfx_req(sfx_req), .bgm_addr(bgm_addr), .bgm_q(bgm_q),
    .sfx_addr(sfx_addr), .sfx_q(sfx_q), .sfx_busy(sfx_busy), .sfx_id(sfx_id),
    .sample_out(sample_out), .write_audio_out(write_audio_out)
  );

  typedef struct packed {
    logic [31:0] sample;
    logic [15:0] bgm;
    logic        busy;
    logic        id;
    logic [15:0] sfx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int gap = 0;
  int strobes = 0;

  // Reference state of the expected behaviour
  int   eb, ea, bq, sq;
  logic ebusy, eid, ben;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    exp_t e, a;
    if (write_audio_out) begin
      gap = cyc - last_cyc;
      last_cyc = cyc;
      strobes++;
      total++;
      a = '{sample_out, bgm_addr, sfx_busy, sfx_id, sfx_addr};
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: cycle=%0d sample=%h", cyc, sample_out);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL strobe%0d: got sample=%h bgm=%0d busy=%b id=%b sfx=%0d, want sample=%h bgm=%0d busy=%b id=%b sfx=%0d",
                   strobes, a.sample, a.bgm, a.busy, a.id, a.sfx, e.sample, e.bgm, e.busy, e.id, e.sfx);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic push_exp(input int s10, input int b, input logic bu, input logic id, input int a);
    exp_t e;
    logic [9:0] v;
    v = 10'(s10);
    e.sample = {v, 22'd0};
    e.bgm    = 16'(b);
    e.busy   = bu;
    e.id     = id;
    e.sfx    = 16'(a);
    q.push_back(e);
  endtask

  task automatic wait_strobe();
    int tgt;
    tgt = strobes + 1;
    for (int i = 0; i < 200 && strobes < tgt; i++) begin
      @(negedge clk);
      #1;
    end
    if (strobes < tgt) begin
      total++;
      bad++;
      $display("FAIL strobe_timeout: got %0d strobes want %0d", strobes, tgt);
      q.delete();
    end
  endtask

  // Expected contents of the next strobe, advancing the reference state
  task automatic model_push();
    int b, s, sum;
    b = 0;
    if (ben) begin
      b = bq;
`ifdef AUDIO_SCHED_DUCK_EN
      if (ebusy) b = bq >>> 1;
`endif
    end
    s = ebusy ? sq : 0;
    sum = b + s;
    if (sum > 511)  sum = 511;
    if (sum < -512) sum = -512;
    if (ben) eb = (eb == int'(BGM_LAST)) ? 0 : eb + 1;
    if (ebusy) begin
      if (ea == (eid ? int'(S1L) : int'(S0L))) ebusy = 1'b0;
      else ea++;
    end
    push_exp(sum, eb, ebusy, eid, ea);
  endtask

  task automatic step();
    model_push();
    wait_strobe();
  endtask

  task automatic set_q(input int b, input int s);
    bq = b;
    sq = s;
    bgm_q = 10'(b);
    sfx_q = 10'(s);
  endtask

  task automatic req(input logic [1:0] r);
    sfx_req = r;
    @(negedge clk);
    sfx_req = 2'b00;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bgm_addr"}, 64'(bgm_addr), 64'd0);
    check({tag, "_sfx_addr"}, 64'(sfx_addr), 64'd0);
    check({tag, "_sample"}, 64'(sample_out), 64'd0);
    check({tag, "_busy"}, 64'(sfx_busy), 64'd0);
    check({tag, "_id"}, 64'(sfx_id), 64'd0);
    check({tag, "_write"}, 64'(write_audio_out), 64'd0);
  endtask

  initial begin
    logic [9:0] tmp10;
    reset = 1'b1;
    audio_out_allowed = 1'b1;
    bgm_en = 1'b1;
    ben = 1'b1;
    sfx_req = 2'b00;
    set_q(100, 0);
    eb = 0; ea = 0; ebusy = 1'b0; eid = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Plain BGM: 100<<22 every 13 cycles, address +1 per strobe
    for (int k = 0; k < 5; k++) begin
      step();
      if (k > 0) check("gap_13", 64'(gap), 64'd13);
    end

    // BGM wrap at BGM_LAST, then freeze with bgm_en low
    for (int k = 0; k < 16; k++) step();
    check("bgm_wrap", 64'(bgm_addr), 64'd0);
    bgm_en = 1'b0; ben = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("bgm_frozen", 64'(bgm_addr), 64'd0);
    check("bgm_off_sample", 64'(sample_out), 64'd0);

    // Both requests at once: effect 1 wins; later effect-0 request ignored
    bgm_en = 1'b1; ben = 1'b1;
    set_q(100, 50);
    req(2'b11);
    check("both_req_id", 64'(sfx_id), 64'd1);
    check("both_req_addr", 64'(sfx_addr), 64'd4096);
    check("both_req_busy", 64'(sfx_busy), 64'd1);
    ebusy = 1'b1; eid = 1'b1; ea = 4096;
    for (int k = 0; k < 3; k++) step();
    req(2'b01);
    check("req0_ignored_id", 64'(sfx_id), 64'd1);
    check("req0_ignored_addr", 64'(sfx_addr), 64'd4099);
    for (int k = 0; k < 13; k++) step();
    check("sfx1_done_busy", 64'(sfx_busy), 64'd0);
    check("sfx1_done_addr", 64'(sfx_addr), 64'd4111);
    step();

    // Effect 1 preempts effect 0
    req(2'b01);
    check("sfx0_start_id", 64'(sfx_id), 64'd0);
    check("sfx0_start_addr", 64'(sfx_addr), 64'd0);
    ebusy = 1'b1; eid = 1'b0; ea = 0;
    step();
    step();
    req(2'b10);
    check("preempt_id", 64'(sfx_id), 64'd1);
    check("preempt_addr", 64'(sfx_addr), 64'd4096);
    eid = 1'b1; ea = 4096;
    step();

    // Saturation in both directions
    set_q(400, 300);
    step();
`ifdef AUDIO_SCHED_DUCK_EN
    check("sat_pos", 64'(sample_out), 64'(32'd500 << 22));
`else
    check("sat_pos", 64'(sample_out), 64'(32'd511 << 22));
`endif
    set_q(-400, -300);
    step();
`ifdef AUDIO_SCHED_DUCK_EN
    tmp10 = 10'(-500);
`else
    tmp10 = 10'(-512);
`endif
    check("sat_neg", 64'(sample_out), 64'({tmp10, 22'd0}));

    // Let effect 1 run out with BGM muted
    bgm_en = 1'b0; ben = 1'b0;
    set_q(100, 20);
    for (int k = 0; k < 40 && ebusy; k++) step();

    // Request landing in MIX overrides the address step
    repeat (11) @(negedge clk);
    sfx_req = 2'b01;
    @(negedge clk);
    sfx_req = 2'b00;
    check("mix_req_addr", 64'(sfx_addr), 64'd0);
    check("mix_req_busy", 64'(sfx_busy), 64'd1);
    push_exp(0, eb, 1'b1, 1'b0, 0);
    wait_strobe();
    ebusy = 1'b1; eid = 1'b0; ea = 0;
    for (int k = 0; k < 20 && ebusy; k++) step();

    // FIFO full for 20 cycles while in WRITE
    bgm_en = 1'b1; ben = 1'b1;
    set_q(100, 0);
    step();
    model_push();
    repeat (11) @(negedge clk);
    audio_out_allowed = 1'b0;
    repeat (20) @(negedge clk);
    audio_out_allowed = 1'b1;
    wait_strobe();
    check("drop_gap", 64'(gap), 64'd32);
    step();
    check("gap_after_drop", 64'(gap), 64'd13);

    // One-cycle reset while in WRITE, with a request pending
    step();
    repeat (12) @(negedge clk);
    reset = 1'b1;
    sfx_req = 2'b10;
    @(negedge clk);
    reset = 1'b0;
    sfx_req = 2'b00;
    check_zero("mid_reset");
    eb = 0; ea = 0; ebusy = 1'b0; eid = 1'b0;
    step();
    check("post_reset_bgm", 64'(bgm_addr), 64'd1);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_sched.md
AUDIO_SCHED -- requirements
Module: audio_sched

Interface
REQ-001 Parameter DIV, default 8, meaning: audio_out_allowed cycles between sample ticks minus one.
REQ-002 Parameter BGM_LAST, default 54205, meaning: last BGM ROM address before wrap to 0.
REQ-003 Parameters SFX0_BASE/SFX0_LAST, defaults 0/4095, meaning: SFX ROM address range of effect 0.
REQ-004 Parameters SFX1_BASE/SFX1_LAST, defaults 4096/8191, meaning: SFX ROM address range of effect 1.
REQ-005 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 audio_out_allowed  in  1  Audio_Controller output FIFO has space.
REQ-008 bgm_en  in  1  level; 1 = background music plays.
REQ-009 sfx_req  in  2  one-cycle request pulses; bit1 = effect 1, bit0 = effect 0.
REQ-010 bgm_addr  out  16  BGM ROM address.
REQ-011 bgm_q  in  10  BGM ROM data, signed, valid 1 cycle after bgm_addr.
REQ-012 sfx_addr  out  16  SFX ROM address.
REQ-013 sfx_q  in  10  SFX ROM data, signed, valid 1 cycle after sfx_addr.
REQ-014 sfx_busy  out  1  an effect is playing.
REQ-015 sfx_id  out  1  index of the playing effect; valid when sfx_busy = 1.
REQ-016 sample_out  out  32  mixed sample driven to both audio channels.
REQ-017 write_audio_out  out  1  one-cycle write strobe to Audio_Controller.

Function
REQ-018 Tick divider SHALL increment only in cycles with audio_out_allowed = 1 and SHALL issue a tick and clear to 0 on reaching DIV.
REQ-019 FSM states SHALL be IDLE, FETCH, WAIT, MIX, WRITE.
REQ-020 Transitions SHALL be: IDLE -> FETCH on tick; FETCH -> WAIT; WAIT -> MIX; MIX -> WRITE; WRITE -> IDLE in the cycle that audio_out_allowed = 1.
REQ-021 write_audio_out SHALL be 1 only in WRITE with audio_out_allowed = 1, for exactly one cycle per tick.
REQ-022 WRITE SHALL hold without strobing while audio_out_allowed = 0, and the divider SHALL not advance while the FSM is outside IDLE.
REQ-023 In MIX, bgm_addr SHALL advance by 1 when bgm_en = 1, or wrap to 0 when it equals BGM_LAST; bgm_addr SHALL hold when bgm_en = 0.
REQ-024 A sfx_req pulse in any state SHALL start the effect: sfx_busy <= 1, sfx_id <= index, sfx_addr <= SFXn_BASE.
REQ-025 If both sfx_req bits are set in one cycle, effect 1 SHALL win.
REQ-026 sfx_req[1] SHALL preempt a playing effect 0; any other request while busy (same or lower index) SHALL be ignored.
REQ-027 In MIX with sfx_busy = 1, sfx_addr SHALL advance by 1; at SFXn_LAST, sfx_busy SHALL clear and sfx_addr SHALL hold.
REQ-028 A request arriving in the same cycle as a MIX-step address update SHALL take precedence over that update.
REQ-029 Mix in MIX state: b = bgm_en ? sign-extended bgm_q : 0; s = sfx_busy ? sign-extended sfx_q : 0.
REQ-030 The mix sum b + s SHALL be computed at 11 bits signed and saturated to 10 bits signed, range -512..511.
REQ-031 sample_out SHALL be {sat10, 22'd0}, registered in MIX and stable through WRITE.
REQ-032 Latency SHALL be 3 cycles from tick to WRITE entry.

Reset
REQ-033 While reset = 1 at a clock edge, the FSM SHALL go to IDLE and the divider SHALL clear to 0.
REQ-034 While reset = 1 at a clock edge, bgm_addr, sfx_addr, sample_out, sfx_busy, sfx_id and write_audio_out SHALL all go to 0.
REQ-035 Reset asserted mid-sequence, including in WRITE, SHALL abort the sequence without emitting a strobe, and pending requests SHALL be discarded.

Configuration
REQ-036 With macro AUDIO_SCHED_DUCK_EN defined, b SHALL be arithmetically shifted right by 1 (bgm_q >>> 1) whenever sfx_busy = 1.
REQ-037 With AUDIO_SCHED_DUCK_EN undefined, b SHALL be unscaled in all cases.

Verification
REQ-038 DIV=8, audio_out_allowed=1, bgm_en=1, bgm_q=100 -> one strobe per 13 cycles, sample_out = 100<<22, bgm_addr +1 per strobe.
REQ-039 bgm_addr = 54205 at MIX -> next bgm_addr = 0; bgm_en=0 -> bgm_addr frozen and sample_out = 0.
REQ-040 sfx_req=2'b11 in one cycle -> sfx_id = 1 and sfx_addr = 4096; a later sfx_req[0] is ignored; sfx_busy clears after the 4096th strobe.
REQ-041 bgm_q=400, sfx_q=300 -> sample_out = 511<<22 (saturated) without the macro, 500<<22 with AUDIO_SCHED_DUCK_EN.
REQ-042 audio_out_allowed dropped for 20 cycles while in WRITE -> no strobe during the drop, then exactly one strobe, with the divider frozen throughout.
REQ-043 reset=1 for one cycle in WRITE -> no strobe and all outputs 0 on the next cycle.
